// File: rtl/lcd_spi_tx_if.sv
// ---------------------------------------------------------------------------
// lcd_spi_tx_if
//   Upstream byte handshake between the display-sequencing FSMs (master) and
//   the PCD8544 SPI transmitter (slave).
//
//   Handshake: `start` is a level that says "keep transmitting". While the
//   transmitter wants a byte it pulses `avail` for exactly one cycle. The
//   master must present `data_in`, `command` and `div_factor` no later than
//   the cycle after `avail` and hold them through the following cycle, when
//   the transmitter captures them. Dropping `start` at any point before that
//   capture cycle ends the stream instead of sending another byte. `busy` is
//   high whenever the transmitter is not idle.
//
//   Signals
//     data_in    [7:0]  byte to send
//     start             level request to keep sending
//     div_factor [15:0] SCLK half-period in clock cycles (0 acts as 1)
//     command           LCD D/C value for the byte (0 = command, 1 = data)
//     busy              transmitter not idle
//     avail             one-cycle request for the next byte
// ---------------------------------------------------------------------------
interface lcd_spi_tx_if;
    logic [7:0]  data_in;
    logic        start;
    logic [15:0] div_factor;
    logic        command;
    logic        busy;
    logic        avail;

    modport master (
        output data_in,
        output start,
        output div_factor,
        output command,
        input  busy,
        input  avail
    );

    modport slave (
        input  data_in,
        input  start,
        input  div_factor,
        input  command,
        output busy,
        output avail
    );
endinterface

// File: rtl/lcd_spi_tx.sv
// ---------------------------------------------------------------------------
// lcd_spi_tx
//   Byte-level SPI transmitter for the PCD8544 (Nokia 5110) LCD. After each
//   release of Reset it issues one LCD hardware reset pulse (rst low for
//   RST_CYCLES, then a settle time of RST_CYCLES), then requests bytes over
//   the upstream handshake and shifts each one out MSB-first with sce/dc
//   framing. SCLK idles low; mosi changes only on SCLK falling edges.
//
//   Ports
//     clock      system clock, rising edge
//     Reset      asynchronous active-low reset
//     up         upstream handshake (lcd_spi_tx_if.slave)
//     mosi       serial data to LCD
//     sclk       serial clock to LCD
//     sce        LCD chip enable, active low
//     dc         LCD data/command select for the byte in flight
//     rst        LCD reset, active low
//     state_dbg  current FSM state
// ---------------------------------------------------------------------------
module lcd_spi_tx #(
    parameter int RST_CYCLES = 1000
) (
    input  logic         clock,
    input  logic         Reset,
    lcd_spi_tx_if.slave  up,
    output logic         mosi,
    output logic         sclk,
    output logic         sce,
    output logic         dc,
    output logic         rst,
    output logic [2:0]   state_dbg
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RST_LO = 3'd1;
    localparam logic [2:0] S_RST_HI = 3'd2;
    localparam logic [2:0] S_REQ    = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_LOAD   = 3'd5;
    localparam logic [2:0] S_SHIFT  = 3'd6;

    localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);

    logic [2:0]     state;
    logic           lcd_init;
    logic [RCW-1:0] rst_cnt;
    logic [2:0]     bit_cnt;
    logic [15:0]    div_cnt;
    logic [15:0]    div_val;
    // Bit 7 goes straight to mosi at capture, so only the remaining 7 bits
    // are held here.
    logic [6:0]     shreg;

    assign up.busy   = (state != S_IDLE);
    assign up.avail  = (state == S_REQ);
    assign state_dbg = state;

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            state    <= S_IDLE;
            lcd_init <= 1'b0;
            rst_cnt  <= '0;
            bit_cnt  <= 3'd0;
            div_cnt  <= 16'd0;
            div_val  <= 16'd0;
            shreg    <= 7'd0;
            mosi     <= 1'b0;
            sclk     <= 1'b0;
            sce      <= 1'b1;
            dc       <= 1'b0;
            rst      <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    sce  <= 1'b1;
                    sclk <= 1'b0;
                    if (up.start) begin
                        if (lcd_init) begin
                            state <= S_REQ;
                        end else begin
                            state   <= S_RST_LO;
                            rst     <= 1'b0;
                            rst_cnt <= '0;
                        end
                    end
                end

                S_RST_LO: begin
                    if (rst_cnt == RST_LAST) begin
                        rst     <= 1'b1;
                        rst_cnt <= '0;
                        state   <= S_RST_HI;
                    end else begin
                        rst_cnt <= rst_cnt + RCW'(1);
                    end
                end

                S_RST_HI: begin
                    if (rst_cnt == RST_LAST) begin
                        rst_cnt  <= '0;
                        lcd_init <= 1'b1;
                        state    <= S_REQ;
                    end else begin
                        rst_cnt <= rst_cnt + RCW'(1);
                    end
                end

                // avail is decoded from this state; it always lasts one cycle.
                S_REQ: state <= S_WAIT;

                // Gives a registered upstream one cycle to react to avail.
                S_WAIT: state <= S_LOAD;

                S_LOAD: begin
                    if (!up.start) begin
                        state <= S_IDLE;
                        sce   <= 1'b1;
                        sclk  <= 1'b0;
                    end else begin
                        shreg   <= up.data_in[6:0];
                        mosi    <= up.data_in[7];
                        dc      <= up.command;
                        div_val <= (up.div_factor == 16'd0) ? 16'd1 : up.div_factor;
                        sce     <= 1'b0;
                        sclk    <= 1'b0;
                        bit_cnt <= 3'd7;
                        div_cnt <= 16'd0;
                        state   <= S_SHIFT;
                    end
                end

                // Each half-period lasts div_val cycles; the compare against
                // div_val-1 keeps 0xFFFF from wrapping the 16-bit counter.
                S_SHIFT: begin
                    if (div_cnt == div_val - 16'd1) begin
                        div_cnt <= 16'd0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else begin
                            sclk <= 1'b0;
                            if (bit_cnt == 3'd0) begin
                                state <= S_REQ;
                            end else begin
                                bit_cnt <= bit_cnt - 3'd1;
                                mosi    <= shreg[6];
                                shreg   <= {shreg[5:0], 1'b0};
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
